// File: rtl/pcm_rx.sv
// -----------------------------------------------------------------------------
// pcm_rx : serial PCM (I2S-format) audio receiver.
//
// bck, lrck and adata are oversampled on the system clock scki and each
// MSB-first channel slot is deserialized into one parallel sample. No clock
// is derived from bck; everything runs on the rising edge of scki.
//
// Parameters
//   DATA_W  sample width in bits (1..SLOT_W)
//   SLOT_W  bck periods per channel slot (lrck half-period)
//
// Ports
//   scki           in   system clock
//   rst            in   synchronous active-high reset
//   bck            in   serial bit clock (asynchronous, >= 8 scki periods)
//   lrck           in   word select, 0 = left, 1 = right (asynchronous)
//   adata          in   serial data, changes on bck falling edges
//   data_parallel  out  last completed sample, held between strobes
//   data_ch        out  channel of data_parallel
//   data_valid     out  one-scki strobe when data_parallel/data_ch update
//   frame_err      out  sticky slot-length error flag
//
// Build option
//   PCM_RX_FRAME_CHECK_EN  when defined, every boundary after the first
//                          checks that the finished slot held SLOT_W bck
//                          rises; otherwise frame_err is tied low.
// -----------------------------------------------------------------------------
module pcm_rx #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              scki,
    input  logic              rst,
    input  logic              bck,
    input  logic              lrck,
    input  logic              adata,
    output logic [DATA_W-1:0] data_parallel,
    output logic              data_ch,
    output logic              data_valid,
    output logic              frame_err
);

    // k saturates at SLOT_W+1, so it needs to hold values 0..SLOT_W+1.
    localparam int K_W = $clog2(SLOT_W + 2);
    localparam logic [K_W-1:0] K_MAX  = K_W'(SLOT_W + 1);
    localparam logic [K_W-1:0] K_DATA = K_W'(DATA_W);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // ---------------------------------------------------------------------
    // Input synchronizers, plus a third flop on bck for edge detection.
    // ---------------------------------------------------------------------
    logic bck_s1_q, bck_s_q, bck_d_q;
    logic lrck_s1_q, lrck_s_q;
    logic adata_s1_q, adata_s_q;

    // NOTE: every flop is written with <= so all of them sample the values
    // from before the edge; blocking writes here would collapse the chain.
    always_ff @(posedge scki) begin
        if (rst) begin
            bck_s1_q   <= 1'b0;
            bck_s_q    <= 1'b0;
            bck_d_q    <= 1'b0;
            lrck_s1_q  <= 1'b0;
            lrck_s_q   <= 1'b0;
            adata_s1_q <= 1'b0;
            adata_s_q  <= 1'b0;
        end else begin
            bck_s1_q   <= bck;
            bck_s_q    <= bck_s1_q;
            bck_d_q    <= bck_s_q;
            lrck_s1_q  <= lrck;
            lrck_s_q   <= lrck_s1_q;
            adata_s1_q <= adata;
            adata_s_q  <= adata_s1_q;
        end
    end

    // ---------------------------------------------------------------------
    // Protocol state
    // ---------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [K_W-1:0]    k_q, k_d, k_inc;
    logic              lrck_prev_q, lrck_prev_d;
    logic              primed_q, primed_d;
    logic              chan_q, chan_d;
    logic [DATA_W-1:0] sr_q, sr_d, sr_shift;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ch_q, ch_d;
    logic              valid_q, valid_d;
    logic              rise, boundary;

    assign rise = bck_s_q & ~bck_d_q;

    // lrck_prev is only meaningful after it has been loaded by one rise
    // since reset; without this, coming out of reset inside a right slot
    // would look like a boundary against the reset value 0.
    assign boundary = rise & primed_q & (lrck_s_q != lrck_prev_q);

    assign k_inc    = (k_q == K_MAX) ? k_q : k_q + 1'b1;
    assign sr_shift = (sr_q << 1) | DATA_W'(adata_s_q);

    // NOTE: every signal assigned below receives a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        lrck_prev_d = lrck_prev_q;
        primed_d    = primed_q;
        chan_d      = chan_q;
        sr_d        = sr_q;
        data_d      = data_q;
        ch_d        = ch_q;
        valid_d     = 1'b0;

        if (rise) begin
            primed_d    = 1'b1;
            lrck_prev_d = lrck_s_q;
            // The bit at the boundary rise (k = 0) still belongs to the
            // previous slot; the new slot's bits sit at k = 1..DATA_W.
            k_d         = boundary ? '0 : k_inc;

            case (state_q)
                ST_SYNC: begin
                    if (boundary) begin
                        state_d = ST_SHIFT;
                        chan_d  = lrck_s_q;
                    end
                end
                ST_SHIFT: begin
                    sr_d = sr_shift;
                    if (boundary) begin
                        // Slot shorter than DATA_W: drop it, start over.
                        chan_d = lrck_s_q;
                    end else if (k_d == K_DATA) begin
                        data_d  = sr_shift;
                        ch_d    = chan_q;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (boundary) begin
                        state_d = ST_SHIFT;
                        chan_d  = lrck_s_q;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge scki) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            k_q         <= '0;
            lrck_prev_q <= 1'b0;
            primed_q    <= 1'b0;
            chan_q      <= 1'b0;
            sr_q        <= '0;
            data_q      <= '0;
            ch_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            lrck_prev_q <= lrck_prev_d;
            primed_q    <= primed_d;
            chan_q      <= chan_d;
            sr_q        <= sr_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
            valid_q     <= valid_d;
        end
    end

    assign data_parallel = data_q;
    assign data_ch       = ch_q;
    assign data_valid    = valid_q;

    // ---------------------------------------------------------------------
    // Optional slot-length check
    // ---------------------------------------------------------------------
`ifdef PCM_RX_FRAME_CHECK_EN
    // A correct slot holds SLOT_W rises at k = 0..SLOT_W-1, so k must read
    // SLOT_W-1 when the next boundary arrives. The boundary that leaves
    // SYNC has no complete slot behind it and is not checked.
    localparam logic [K_W-1:0] K_LAST = K_W'(SLOT_W - 1);

    logic frame_err_q;

    always_ff @(posedge scki) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else if (boundary && (state_q != ST_SYNC) && (k_q != K_LAST)) begin
            frame_err_q <= 1'b1;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
